// File: rtl/fast_inv_sqrt_mc.sv
// fast_inv_sqrt_mc: multi-channel fixed-point inverse square root on a
// Wishbone classic slave. NCH channels share one bit-serial core that is
// scheduled round-robin; per-channel pending/done status plus maskable irq.
`timescale 1ns/1ps
module fast_inv_sqrt_mc #(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int NCH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   adr_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    input  logic          we_i,
    input  logic          stb_i,
    input  logic          cyc_i,
    output logic          ack_o,
    output logic          irq_o
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int PW = 3 * DW;
    // y^2 * x is compared against 2^(3*FRAC); PW bits hold both without loss
    localparam logic [PW-1:0] LIMIT = PW'(1) << (3 * FRAC);

    typedef enum logic [1:0] {IDLE, ITER, WB} state_t;

    state_t                   state, state_n;
    logic [NCH-1:0][DW-1:0]   operand, result;
    logic [NCH-1:0]           pending, done, irq_en;
    logic [DW-1:0]            x, y, trial, rdata;
    logic [BW-1:0]            bit_idx;
    logic [CW-1:0]            grant, last_grant, gnt_idx, cand;
    logic                     gnt_found, stale, load, wb;
    logic [PW-1:0]            prod;
    logic                     trial_ok;
    logic                     access, wr;
    logic [3:0]               idx;
    logic [NCH-1:0]           ch_wr, done_clr, gnt_oh, cur_oh, inflight, wb_set;
    logic                     unused;

    // Only the register index bits of the address matter
    assign unused = ^{adr_i[31:6], adr_i[1:0]};

    assign access = stb_i & cyc_i & ~ack_o;
    assign wr     = access & we_i;
    assign idx    = adr_i[5:2];

    assign gnt_oh   = NCH'(1) << gnt_idx;
    assign cur_oh   = NCH'(1) << grant;
    assign inflight = (state != IDLE) ? cur_oh : '0;
    assign wb_set   = (wb && !stale) ? cur_oh : '0;
    assign done_clr = (wr && idx == 4'd9) ? dat_i[NCH-1:0] : '0;
    assign irq_o    = |(done & irq_en);

    // Trial of the current bit: keep it while y^2*x stays within the limit
    assign trial    = y | (DW'(1) << bit_idx);
    assign prod     = PW'(trial) * PW'(trial) * PW'(x);
    assign trial_ok = (prod <= LIMIT);

    // Decode per-channel operand writes
    always_comb begin
        ch_wr = '0;
        for (int n = 0; n < NCH; n++)
            if (wr && idx == 4'(n)) ch_wr[CW'(n)] = 1'b1;
    end

    // Round-robin pick: first pending channel after the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = CW'((int'(last_grant) + i) % NCH);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        for (int n = 0; n < NCH; n++)
            if (idx == 4'(n)) rdata = result[CW'(n)];
        case (idx)
            4'd8:    rdata[NCH-1:0] = pending | inflight;
            4'd9:    rdata[NCH-1:0] = done;
            4'd10:   rdata[NCH-1:0] = irq_en;
            default: ;
        endcase
    end

    // Scheduler FSM next-state and control strobes
    always_comb begin
        state_n = state;
        load    = 1'b0;
        wb      = 1'b0;
        case (state)
            IDLE: if (gnt_found) begin
                state_n = ITER;
                load    = 1'b1;
            end
            ITER: if (bit_idx == '0) state_n = WB;
            WB: begin
                wb      = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Core datapath: load on grant, one bit per ITER cycle, stale tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            bit_idx    <= '0;
            grant      <= '0;
            last_grant <= CW'(NCH - 1);
            stale      <= 1'b0;
        end else if (load) begin
            x          <= operand[gnt_idx];
            y          <= '0;
            bit_idx    <= BW'(DW - 1);
            grant      <= gnt_idx;
            last_grant <= gnt_idx;
            // a rewrite on the grant edge means x holds the old operand
            stale      <= ch_wr[gnt_idx];
        end else begin
            if (state == ITER) begin
                if (trial_ok) y <= trial;
                if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
            end
            if (state != IDLE && ch_wr[grant]) stale <= 1'b1;
        end
    end

    // Channel registers: operands, results, pending, done, irq enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand <= '0;
            result  <= '0;
            pending <= '0;
            done    <= '0;
            irq_en  <= '0;
        end else begin
            for (int n = 0; n < NCH; n++)
                if (ch_wr[CW'(n)]) operand[CW'(n)] <= dat_i;
            if (wb && !stale) result[grant] <= y;
            pending <= (pending & ~(load ? gnt_oh : '0)) | ch_wr;
            // WB set beats a DONE clear; a fresh operand write beats WB set
            done    <= ((done & ~done_clr) | wb_set) & ~ch_wr;
            if (wr && idx == 4'd10) irq_en <= dat_i[NCH-1:0];
        end
    end

    // Bus response: one-cycle ack with registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= access;
            dat_o <= (access && !we_i) ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_fast_inv_sqrt_mc.sv
// Directed + randomized bench for fast_inv_sqrt_mc (DW=16, FRAC=8, NCH=4).
`timescale 1ns/1ps
module tb_fast_inv_sqrt_mc;
    localparam int DW = 16, FRAC = 8, NCH = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic [31:0]   adr_i = '0;
    logic [DW-1:0] dat_i = '0;
    logic          we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic [DW-1:0] dat_o;
    logic          ack_o, irq_o;
    int            passes = 0, checks = 0;

    fast_inv_sqrt_mc #(.DW(DW), .FRAC(FRAC), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: largest y in [0,65535] with y*y*x <= 2^(3*FRAC)
    function automatic logic [15:0] ref_isqrt(input logic [15:0] x);
        longint lim, xv, yv;
        lim = longint'(1) << (3 * FRAC);
        xv  = longint'(x);
        if (xv == 0) return 16'hFFFF;
        yv = longint'($sqrt(real'(lim) / real'(xv)));
        if (yv > 65535) yv = 65535;
        while (yv > 0 && yv * yv * xv > lim) yv--;
        while (yv < 65535 && (yv + 1) * (yv + 1) * xv <= lim) yv++;
        return 16'(yv);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wb(input bit w, input int idx, input logic [15:0] d, output logic [15:0] q);
        bit got;
        got = 1'b0;
        q = '0;
        @(negedge clk);
        adr_i = 32'(idx) << 2; dat_i = d; we_i = w; stb_i = 1'b1; cyc_i = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack_o) begin got = 1'b1; q = dat_o; end
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        if (!got) chk("wb_ack", 32'(got), 1);
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        logic [15:0] q;
        wb(1'b1, idx, d, q);
    endtask

    task automatic rd(input int idx, output logic [15:0] q);
        wb(1'b0, idx, 16'h0, q);
    endtask

    task automatic wait_irq(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(posedge clk); #1;
            if (irq_o) seen = 1'b1;
        end
        if (!seen) chk("irq_timeout", 32'(irq_o), 1);
    endtask

    // Write an idle-core operand, check exact latency via irq, result, clear
    task automatic run_single(input int ch, input logic [15:0] x, input logic [15:0] exp);
        logic [15:0] q;
        wr(ch, x);
        repeat (17) @(posedge clk);
        #1 chk($sformatf("lat_early ch%0d x=%0h", ch, x), 32'(irq_o), 0);
        @(posedge clk);
        #1 chk($sformatf("lat_done ch%0d x=%0h", ch, x), 32'(irq_o), 1);
        rd(ch, q);
        chk($sformatf("result ch%0d x=%0h", ch, x), 32'(q), 32'(exp));
        wr(9, 16'(1 << ch));
        chk("irq_clr", 32'(irq_o), 0);
    endtask

    initial begin
        logic [15:0] q, x1, x2;
        logic [15:0] xs [5];
        logic [15:0] es [5];
        logic [15:0] rr_x [4];
        int          order [$];
        logic [3:0]  seen, nw;
        int          ch;

        xs = '{16'h0100, 16'h0400, 16'h0008, 16'h0001, 16'h0000};
        es = '{16'h0100, 16'h0080, 16'h05A8, 16'h1000, 16'hFFFF};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        for (int i = 0; i < 16; i++) begin
            rd(i, q);
            chk($sformatf("rst_rd idx%0d", i), 32'(q), 0);
        end
        repeat (DW + 4) @(posedge clk);
        rd(8, q);
        chk("idle_status", 32'(q), 0);

        // Directed single operands on CH0
        wr(10, 16'h1);
        for (int i = 0; i < 5; i++) run_single(0, xs[i], es[i]);

        // Random operands on random channels
        wr(10, 16'hF);
        for (int i = 0; i < 8; i++) begin
            ch = int'($urandom_range(0, NCH - 1));
            x1 = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            run_single(ch, x1, ref_isqrt(x1));
        end

        // Round robin: queue 2,0,3,1 and observe completion order
        for (int i = 0; i < 4; i++) rr_x[i] = 16'($urandom_range(1, 16'hFFFF));
        wr(2, rr_x[2]); wr(0, rr_x[0]); wr(3, rr_x[3]); wr(1, rr_x[1]);
        seen = '0;
        for (int it = 0; it < 200 && order.size() < 4; it++) begin
            rd(9, q);
            nw = q[3:0] & ~seen;
            if (nw != 0) begin
                if (order.size() == 0) chk("rr_irq_first", 32'(irq_o), 1);
                for (int b = 0; b < 4; b++) if (nw[b]) order.push_back(b);
                seen = seen | nw;
            end
        end
        chk("rr_count", 32'(order.size()), 4);
        while (order.size() < 4) order.push_back(-1);
        chk("rr_order0", 32'(order[0]), 2);
        chk("rr_order1", 32'(order[1]), 3);
        chk("rr_order2", 32'(order[2]), 0);
        chk("rr_order3", 32'(order[3]), 1);
        for (int i = 0; i < 4; i++) begin
            rd(i, q);
            chk($sformatf("rr_result ch%0d", i), 32'(q), 32'(ref_isqrt(rr_x[i])));
        end
        for (int k = 0; k < 4; k++) begin
            wr(9, 16'(1 << k));
            chk($sformatf("rr_irq_after_clr%0d", k), 32'(irq_o), (k < 3) ? 1 : 0);
        end

        // Stale rewrite on CH1
        wr(10, 16'h2);
        wr(1, 16'h0100);
        repeat (4) @(posedge clk);
        wr(1, 16'h0400);
        repeat (13) @(posedge clk);
        #1 chk("stale_no_done", 32'(irq_o), 0);
        rd(8, q);
        chk("stale_status", 32'(q[1]), 1);
        repeat (16) @(posedge clk);
        #1 chk("stale_early", 32'(irq_o), 0);
        @(posedge clk);
        #1 chk("stale_done", 32'(irq_o), 1);
        rd(1, q);
        chk("stale_result", 32'(q), 32'h0080);
        wr(9, 16'h2);

        // DONE clear colliding with WB: set wins
        wr(10, 16'h1);
        x1 = 16'($urandom_range(1, 16'hFFFF));
        wr(0, x1);
        repeat (17) @(posedge clk);
        wr(9, 16'h1);
        chk("coll_clr_irq", 32'(irq_o), 1);
        rd(9, q);
        chk("coll_clr_done", 32'(q), 1);
        rd(0, q);
        chk("coll_clr_result", 32'(q), 32'(ref_isqrt(x1)));
        wr(9, 16'h1);

        // CH write colliding with its own WB
        x1 = 16'($urandom_range(1, 16'hFFFF));
        x2 = 16'($urandom_range(1, 16'hFFFF));
        wr(0, x1);
        repeat (17) @(posedge clk);
        wr(0, x2);
        rd(8, q);
        chk("coll_wr_status", 32'(q), 1);
        rd(9, q);
        chk("coll_wr_done", 32'(q), 0);
        rd(0, q);
        chk("coll_wr_result_old", 32'(q), 32'(ref_isqrt(x1)));
        wait_irq(40);
        rd(0, q);
        chk("coll_wr_result_new", 32'(q), 32'(ref_isqrt(x2)));
        wr(9, 16'h1);

        // Reset in the middle of a computation
        wr(10, 16'hF);
        wr(0, 16'h0123);
        wr(3, 16'h0456);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1 chk("mrst_ack", 32'(ack_o), 0);
        chk("mrst_irq", 32'(irq_o), 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(i, q);
            chk($sformatf("mrst_result ch%0d", i), 32'(q), 0);
        end
        rd(8, q);  chk("mrst_status", 32'(q), 0);
        rd(9, q);  chk("mrst_done", 32'(q), 0);
        rd(10, q); chk("mrst_irq_en", 32'(q), 0);
        repeat (DW + 4) @(posedge clk);
        rd(8, q);  chk("mrst_status_later", 32'(q), 0);
        wr(10, 16'h1);
        run_single(0, 16'h0400, 16'h0080);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fast_inv_sqrt_mc.md
# fast_inv_sqrt_mc

Multi-channel, parametrised inverse-square-root accelerator on a Wishbone classic slave port. It succeeds the single-channel fastInvSqrt_top peripheral in the attitude-sensor path. NCH independent operand/result channels share one bit-serial fixed-point core under a round-robin scheduler. Per-channel busy/done status and a maskable interrupt let the Madgwick firmware queue all quaternion-norm operands and collect results without polling each one.

## Interface
- DW, 16: data/operand/result width; Wishbone data width
- FRAC, 8: fractional bits of the unsigned Q(DW-FRAC).FRAC format; 0 ≤ FRAC ≤ DW-1
- NCH, 4: channel count; 1 ≤ NCH ≤ 8 and NCH ≤ DW
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- adr_i  in  32  byte address; register index = adr_i[5:2], other bits ignored
- dat_i  in  DW  write data
- dat_o  out  DW  read data, valid while ack_o high
- we_i  in  1  1 = write, 0 = read
- stb_i  in  1  Wishbone strobe
- cyc_i  in  1  Wishbone cycle
- ack_o  out  1  one-cycle acknowledge
- irq_o  out  1  high while (DONE & IRQ_EN) ≠ 0

## Operation
- Register index 0..NCH-1: CHn.
  - Write: latch operand[n], set pending[n], clear done[n].
  - Read: result[n], the last completed value.
- Index 8: STATUS, read-only, [NCH-1:0] = pending | in-flight.
- Index 9: DONE. Read = done bits. Write 1 to a bit to clear it.
- Index 10: IRQ_EN, read/write, [NCH-1:0].
- Unmapped indices and unused bits read 0. Writes to them are ignored.
- Core function: y = largest value in [0, 2^DW-1] with y²·x ≤ 2^(3·FRAC), i.e. floor(2^FRAC/√(x/2^FRAC)), saturating.
  - x = 0 gives all-ones.
  - Computed MSB-first, one bit per cycle: trial = y | (1<<b); keep the bit if trial²·x ≤ 2^(3·FRAC).
  - Intermediate product width is 3·DW bits. No truncation is allowed.
- FSM states:
  - IDLE: if any pending bit is set, grant the first pending channel at or after last_grant+1 (mod NCH). Load x, set y=0, b=DW-1, clear pending[grant], clear stale. Go to ITER.
  - ITER: one trial per cycle. Go to WB after b=0.
  - WB: if stale, discard the result (the channel remains pending). Otherwise write result[grant] and set done[grant]. Go to IDLE.
- A CHn write while channel n is in flight sets pending[n] and stale. The new operand is recomputed later and no done is raised for the old one.
- A DONE clear in the same cycle as WB setting the same bit: the set wins.
- A CHn write in the same cycle as WB for channel n: result is written, done stays clear, pending is set.
- Reset (any time, including mid-computation): FSM to IDLE, all operands, results, pending, done, IRQ_EN, last_grant (=NCH-1) to 0/defaults. dat_o=0, ack_o=0, irq_o=0.

## Timing
- ack_o is registered: asserted the cycle after stb_i&cyc_i is sampled high with ack_o low. It is high exactly one cycle and never back-to-back. A held strobe produces a new ack every second cycle.
- The register write takes effect on the same edge that raises ack_o. Read data is registered alongside ack_o.
- Latency for an idle core: write edge E0 → grant/load at E1 → DW ITER edges → WB at E(DW+2). done/irq_o are visible after edge E(DW+2): 18 cycles for DW=16.
- Throughput: one result per DW+2 cycles. A queued channel waits at most (NCH-1)·(DW+2) extra cycles.
- irq_o is combinational from registered DONE and IRQ_EN and has no extra cycle.

## Test plan
- Reset values: after reset, read every index → all 0, irq_o=0; wait DW+4 cycles → STATUS stays 0.
- Single operands (DW=16, FRAC=8), write CH0 then poll DONE:
  - 0x0100 → 0x0100
  - 0x0400 → 0x0080
  - 0x0008 → 0x05A8
  - 0x0001 → 0x1000
  - 0x0000 → 0xFFFF
  - Each result is available 18 cycles after the write ack.
- Round robin: write CH2, CH0, CH3, CH1 back-to-back with IRQ_EN=0xF. Completion order is 2,3,0,1; irq_o rises after the first completion; clearing DONE bit by bit drops irq_o after the last clear.
- Stale rewrite: write CH1=0x0100 and, 5 cycles later, CH1=0x0400. No done at the first WB; done[1] rises one computation later with result 0x0080.
- Collisions: a DONE clear coinciding with WB → bit stays set. A CH write coinciding with its own WB → result updated, done=0, STATUS bit=1.
- Reset mid-ITER: assert rst during computation → STATUS/DONE/results 0, ack_o/irq_o 0; a subsequent operation completes normally.
